// File: rtl/tdc_stream_sequencer.sv
// Captures up to DATA_NUM photon timestamps per pixel during a fixed window after each
// laser sync, then streams them out pixel-major with all-ones filling the empty slots.
//
// state     | meaning
// S_IDLE    | waiting for acq_start
// S_CAPTURE | WINDOW-cycle capture window, pixels store hits in parallel
// S_DRAIN   | one word per cycle, PIXELS*DATA_NUM words, wrEn high throughout
module tdc_stream_sequencer #(
  parameter int NP       = 16,
  parameter int PIXELS   = 4,
  parameter int DATA_NUM = 2,
  parameter int ACQ_NUM  = 4,
  parameter int WINDOW   = 64
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 acq_start,
  input  logic [PIXELS-1:0]    ts_valid,
  input  logic [PIXELS*NP-1:0] ts_data,
  output logic                 wrEn,
  output logic [NP-1:0]        data,
  output logic                 acq_done,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int N  = PIXELS * DATA_NUM;
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DATA_NUM + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_win;
  logic [DW-1:0]   r_didx;
  logic [AW-1:0]   r_acq;
  logic [CW-1:0]   r_cnt      [PIXELS];
  logic [NP-1:0]   r_slot     [PIXELS][DATA_NUM];
  logic [CW-1:0]   w_cnt_nxt  [PIXELS];
  logic [NP-1:0]   w_slot_nxt [PIXELS][DATA_NUM];
  logic [DW:0]     w_fetch_idx;
  logic            w_last_fetch;
  logic [NP-1:0]   w_word;

  always_comb begin
    w_slot_nxt = r_slot;
    w_cnt_nxt  = r_cnt;
    if (r_state == S_IDLE && acq_start) begin
      for (int p = 0; p < PIXELS; p++) w_cnt_nxt[p] = '0;
    end else if (r_state == S_CAPTURE) begin
      for (int p = 0; p < PIXELS; p++) begin
        if (ts_valid[p] && r_cnt[p] < CW'(DATA_NUM)) begin
          for (int s = 0; s < DATA_NUM; s++)
            if (r_cnt[p] == CW'(s)) w_slot_nxt[p][s] = ts_data[p*NP +: NP];
          w_cnt_nxt[p] = r_cnt[p] + CW'(1);
        end
      end
    end
  end

  // Word fetched for the next output cycle; the first one must see a hit landing on the
  // final capture cycle, hence reading the next-state storage rather than r_slot.
  assign w_fetch_idx  = (r_state == S_DRAIN) ? ({1'b0, r_didx} + (DW+1)'(1)) : '0;
  assign w_last_fetch = (w_fetch_idx == (DW+1)'(N-1));

  always_comb begin
    w_word = {NP{1'b1}};
    for (int p = 0; p < PIXELS; p++)
      for (int s = 0; s < DATA_NUM; s++)
        if (w_fetch_idx == (DW+1)'(p*DATA_NUM + s) && w_cnt_nxt[p] > CW'(s))
          w_word = w_slot_nxt[p][s];
  end

  always_ff @(posedge clk) begin
    r_slot <= w_slot_nxt;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_didx     <= '0;
      r_acq      <= '0;
      for (int p = 0; p < PIXELS; p++) r_cnt[p] <= '0;
      wrEn       <= 1'b0;
      data       <= '0;
      acq_done   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (acq_done) r_acq <= frame_done ? '0 : r_acq + AW'(1);
      case (r_state)
        S_IDLE: begin
          if (acq_start) begin
            r_state <= S_CAPTURE;
            r_win   <= '0;
          end
        end
        S_CAPTURE: begin
          if (acq_start) overrun <= 1'b1;
          if (r_win == WW'(WINDOW-1)) begin
            r_state    <= S_DRAIN;
            r_didx     <= '0;
            wrEn       <= 1'b1;
            data       <= w_word;
            acq_done   <= w_last_fetch;
            frame_done <= w_last_fetch && (r_acq == AW'(ACQ_NUM-1));
          end else begin
            r_win <= r_win + WW'(1);
          end
        end
        S_DRAIN: begin
          if (acq_start) overrun <= 1'b1;
          if (r_didx == DW'(N-1)) begin
            r_state    <= S_IDLE;
            wrEn       <= 1'b0;
            data       <= '0;
            acq_done   <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            r_didx     <= r_didx + DW'(1);
            data       <= w_word;
            acq_done   <= w_last_fetch;
            frame_done <= w_last_fetch && (r_acq == AW'(ACQ_NUM-1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Scoreboard bench: a per-pixel list model predicts each drained word; a negedge monitor
// pops and compares whenever wrEn is high.
module tb_tdc_stream_sequencer;

  localparam int NP       = 8;
  localparam int PIXELS   = 2;
  localparam int DATA_NUM = 2;
  localparam int ACQ_NUM  = 2;
  localparam int WINDOW   = 4;
  localparam int N        = PIXELS * DATA_NUM;

  logic                 clk = 1'b0;
  logic                 res;
  logic                 acq_start;
  logic [PIXELS-1:0]    ts_valid;
  logic [PIXELS*NP-1:0] ts_data;
  logic                 wrEn;
  logic [NP-1:0]        data;
  logic                 acq_done;
  logic                 frame_done;
  logic                 overrun;

  tdc_stream_sequencer #(
    .NP(NP), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .res(res), .acq_start(acq_start), .ts_valid(ts_valid), .ts_data(ts_data),
    .wrEn(wrEn), .data(data), .acq_done(acq_done), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] d;
    logic          ad;
    logic          fd;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            acq_idx  = 0;
  logic          exp_ovr  = 1'b0;
  logic [NP-1:0] lst [PIXELS][$];
  logic [PIXELS-1:0] pat_v [WINDOW];
  logic [NP-1:0]     pat_d [WINDOW][PIXELS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wrEn", 32'(wrEn), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("drain_word", {22'd0, data, acq_done, frame_done}, {22'd0, e.d, e.ad, e.fd});
      end
    end else begin
      chk("idle_outputs", {22'd0, data, acq_done, frame_done}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pat();
    for (int c = 0; c < WINDOW; c++) begin
      pat_v[c] = '0;
      for (int p = 0; p < PIXELS; p++) pat_d[c][p] = '0;
    end
  endtask

  task automatic hit(input int c, input int p, input logic [NP-1:0] d);
    pat_v[c][p] = 1'b1;
    pat_d[c][p] = d;
  endtask

  task automatic rand_pat();
    for (int c = 0; c < WINDOW; c++) begin
      pat_v[c] = PIXELS'($urandom);
      for (int p = 0; p < PIXELS; p++) pat_d[c][p] = NP'($urandom);
    end
  endtask

  // ovr_cap: capture cycle to pulse acq_start (-1 none); ovr_last: pulse in last drain cycle;
  // rst_k: drain cycle in which res is pulled low (-1 none).
  task automatic do_acq(input int ovr_cap, input bit ovr_last, input int rst_k);
    ts_valid  = PIXELS'($urandom);
    ts_data   = (PIXELS*NP)'($urandom);
    acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    for (int p = 0; p < PIXELS; p++) lst[p].delete();
    for (int c = 0; c < WINDOW; c++) begin
      ts_valid = pat_v[c];
      for (int p = 0; p < PIXELS; p++) ts_data[p*NP +: NP] = pat_d[c][p];
      acq_start = (c == ovr_cap);
      if (c == ovr_cap) exp_ovr = 1'b1;
      for (int p = 0; p < PIXELS; p++)
        if (pat_v[c][p] && lst[p].size() < DATA_NUM) lst[p].push_back(pat_d[c][p]);
      tick();
    end
    acq_start = 1'b0;
    for (int p = 0; p < PIXELS; p++)
      for (int s = 0; s < DATA_NUM; s++) begin
        exp_t e;
        e.d  = (s < lst[p].size()) ? lst[p][s] : {NP{1'b1}};
        e.ad = (p == PIXELS-1) && (s == DATA_NUM-1);
        e.fd = e.ad && (acq_idx == ACQ_NUM-1);
        sb.push_back(e);
      end
    for (int k = 0; k < N; k++) begin
      ts_valid = PIXELS'($urandom);
      ts_data  = (PIXELS*NP)'($urandom);
      if (k == rst_k) begin
        res = 1'b0;
        #1;
        chk("rst_wrEn", 32'(wrEn), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        sb.delete();
        acq_idx = 0;
        exp_ovr = 1'b0;
        tick();
        tick();
        res = 1'b1;
        tick();
        tick();
        chk("post_rst_wrEn", 32'(wrEn), 32'd0);
        ts_valid = '0;
        return;
      end
      if (ovr_last && k == N-1) begin
        acq_start = 1'b1;
        exp_ovr   = 1'b1;
      end
      tick();
    end
    acq_start = 1'b0;
    ts_valid  = '0;
    chk("drain_len", 32'(sb.size()), 32'd0);
    chk("wrEn_after_drain", 32'(wrEn), 32'd0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    acq_idx = (acq_idx + 1) % ACQ_NUM;
  endtask

  initial begin
    res       = 1'b0;
    acq_start = 1'b0;
    ts_valid  = '0;
    ts_data   = '0;
    tick();
    tick();
    chk("reset_wrEn", 32'(wrEn), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_acq_done", 32'(acq_done), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    res = 1'b1;
    tick();

    clr_pat();
    hit(0, 0, 8'h10);
    hit(1, 0, 8'h20);
    hit(1, 1, 8'h30);
    do_acq(-1, 1'b0, -1);

    clr_pat();
    do_acq(-1, 1'b0, -1);

    clr_pat();
    for (int c = 0; c < 3; c++) begin
      hit(c, 0, NP'(c + 1));
      hit(c, 1, NP'(c + 4));
    end
    do_acq(-1, 1'b0, -1);

    clr_pat();
    hit(3, 0, 8'hA5);
    hit(3, 1, 8'h5A);
    do_acq(2, 1'b1, -1);

    for (int i = 0; i < 6; i++) begin
      rand_pat();
      do_acq(-1, 1'b0, -1);
    end

    rand_pat();
    do_acq(-1, 1'b0, 1);

    clr_pat();
    hit(2, 1, 8'h77);
    hit(3, 1, 8'h88);
    hit(3, 0, 8'h99);
    do_acq(-1, 1'b0, -1);

    for (int i = 0; i < 5; i++) begin
      rand_pat();
      do_acq(-1, 1'b0, -1);
      tick();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdc_stream_sequencer.md
TDC_STREAM_SEQUENCER -- requirements
Module: tdc_stream_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): NP 16 timestamp width; PIXELS 4 pixels per RAM; DATA_NUM 2 timestamps per pixel per acquisition; ACQ_NUM 4 acquisitions per histogram; WINDOW 64 capture cycles per acquisition.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 sole clock; one clock, reset is asynchronous and active-low, named res.
REQ-003 acq_start in 1 laser-sync pulse that opens one acquisition.
REQ-004 ts_valid in PIXELS, one bit per pixel: photon timestamp present this cycle.
REQ-005 ts_data in PIXELS*NP; pixel p occupies bits [p*NP +: NP].
REQ-006 wrEn out 1, registered: data word valid toward the histogram builder.
REQ-007 data out NP, registered: timestamp word.
REQ-008 acq_done out 1: one-cycle pulse on the last drain word of each acquisition.
REQ-009 frame_done out 1: one-cycle pulse on the last drain word of acquisition ACQ_NUM-1.
REQ-010 overrun out 1: sticky; set when acq_start arrives outside IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> CAPTURE -> DRAIN -> IDLE.
REQ-012 IDLE: when acq_start is sampled high, SHALL clear all per-pixel slot counters and enter CAPTURE at the next edge.
REQ-013 CAPTURE SHALL last exactly WINDOW cycles, tracked by a window counter of width clog2(WINDOW).
REQ-014 When the counter reaches WINDOW-1, SHALL enter DRAIN at the next edge.
REQ-015 CAPTURE: for each pixel p, on each cycle with ts_valid[p]=1 and slot count < DATA_NUM, SHALL store ts_data[p] in slot[p][count] and increment count.
REQ-016 Extra hits for a full pixel (count = DATA_NUM) SHALL be dropped silently.
REQ-017 All pixels SHALL capture in parallel; simultaneous hits on different pixels SHALL all be kept.
REQ-018 ts_valid SHALL be ignored outside CAPTURE.
REQ-019 DRAIN order: pixel 0 to PIXELS-1; within each pixel, slot 0 to DATA_NUM-1; one word per cycle, no gaps.
REQ-020 wrEn SHALL be high for exactly PIXELS*DATA_NUM consecutive cycles per acquisition.
REQ-021 The first wrEn cycle SHALL be the cycle after the edge that enters DRAIN.
REQ-022 An empty slot (index >= that pixel's count) SHALL emit data = all-ones (no-photon code), so the downstream input/pixel counters stay aligned.
REQ-023 After the last drain word, SHALL return to IDLE; wrEn SHALL be 0 in the following cycle.
REQ-024 An acquisition counter (0..ACQ_NUM-1) SHALL increment on each acq_done and wrap to 0 on frame_done.
REQ-025 acq_done and frame_done SHALL be coincident with the final wrEn=1 cycle.
REQ-026 acq_start during CAPTURE or DRAIN (including the final drain cycle) SHALL be ignored and SHALL set overrun; there is no queuing.
REQ-027 acq_start in the first IDLE cycle after DRAIN SHALL be accepted normally.
REQ-028 While wrEn=0, data SHALL hold 0.

Reset
REQ-029 res low SHALL asynchronously force state IDLE and clear all counters and overrun.
REQ-030 res low SHALL force wrEn=0, data=0, acq_done=0, frame_done=0.
REQ-031 Slot storage needs no reset; the cleared counters make it unreachable.
REQ-032 Reset mid-CAPTURE or mid-DRAIN SHALL abort the acquisition with no further wrEn.
REQ-033 After res rises, the block SHALL wait in IDLE for a fresh acq_start.

Verification (NP=8, PIXELS=2, DATA_NUM=2, ACQ_NUM=2, WINDOW=4)
REQ-034 Basic acquisition: acq_start, then p0 hits 0x10 and 0x20, p1 hit 0x30 -> wrEn high for 4 cycles, data 0x10,0x20,0x30,0xFF; acq_done on 4th cycle.
REQ-035 Frame completion: two back-to-back acquisitions -> frame_done only on the second acquisition's 4th wrEn cycle; acquisition counter returns to 0.
REQ-036 Overflow and simultaneity: p0 hits on 3 cycles (0x01,0x02,0x03) while p1 hits in the same cycles (0x04,0x05,0x06) -> data 0x01,0x02,0x04,0x05.
REQ-037 Overrun: acq_start pulsed in CAPTURE cycle 2 and again in the last DRAIN cycle -> both ignored, overrun=1, exactly 4 wrEn cycles.
REQ-038 No hits: acquisition with no ts_valid -> data 0xFF x4.
REQ-039 Reset mid-operation: res low during the 2nd DRAIN cycle -> wrEn=0 immediately; a new acq_start after release drains a fresh, correct set.
